// File: rtl/mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul_arbiter_if
// Requester-side bus of the shared-multiplier arbiter: per-requester operation
// requests with operands, one-hot grants, and per-requester result buffers.
//   req_valid[N]    requester -> arbiter : operation request
//   req_ready[N]    arbiter -> requester : one-hot grant
//   req_x/req_y     requester -> arbiter : 4-bit operands, lane i at [4i+3:4i]
//   rsp_valid[N]    arbiter -> requester : result available
//   rsp_ready[N]    requester -> arbiter : result accept
//   rsp_data        arbiter -> requester : 8-bit products, lane i at [8i+7:8i]
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mul_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_x;
    logic [4*N-1:0] req_y;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [8*N-1:0] rsp_data;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
// Shares one pipelined 4x4 multiplier (latency LAT) among N requesters.
// Round-robin grants issue straight to the multiplier in the grant cycle; a
// tag pipeline tracks which requester owns each result, and results land in
// per-requester buffers that hold until accepted. Each requester has at most
// one operation outstanding.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus (slave)         requester bus (see mul_arbiter_if)
//   mul_i_valid/x/y     issue port to the shared multiplier
//   mul_cout/o_valid    result port from the shared multiplier
//   busy                any tag in flight or any result buffered
//   err                 sticky: result/tag misalignment seen
// ---------------------------------------------------------------------------
module mul_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    mul_arbiter_if.slave bus,
    output logic         mul_i_valid,
    output logic [3:0]   mul_x,
    output logic [3:0]   mul_y,
    input  logic [7:0]   mul_cout,
    input  logic         mul_o_valid,
    output logic         busy,
    output logic         err
);
    localparam int IW = $clog2(N);

    typedef struct packed {
        logic          v;
        logic [IW-1:0] id;
    } tag_t;

    tag_t           tag_q [LAT];
    logic [N-1:0]   pend_q;
    logic [N-1:0]   pend_d;
    logic [N-1:0]   rsp_valid_q;
    logic [N-1:0]   rsp_valid_d;
    logic [8*N-1:0] rsp_data_q;
    logic [8*N-1:0] rsp_data_d;
    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  ptr_d;
    logic           err_q;
    logic           err_d;

    logic [N-1:0]   elig_s;
    logic [N-1:0]   grant_s;
    logic [N-1:0]   rsp_hs_s;
    logic [IW-1:0]  gnt_id_s;
    logic           wb_s;
    logic           tag_any_s;
    tag_t           tail_s;

    // Round-robin pick: first eligible requester scanning upward from ptr_q.
    // Reset masks eligibility so no handshake can happen while rst is high.
    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        logic          hit;
        elig_s   = bus.req_valid & ~pend_q & {N{~rst}};
        grant_s  = '0;
        gnt_id_s = '0;
        idx      = '0;
        found    = 1'b0;
        hit      = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx          = ptr_q + IW'(k);
            hit          = elig_s[idx] & ~found;
            grant_s[idx] = hit;
            gnt_id_s     = hit ? idx : gnt_id_s;
            found        = found | hit;
        end
    end

    assign bus.req_ready = grant_s;
    assign mul_i_valid   = |grant_s;
    assign mul_x         = mul_i_valid ? bus.req_x[4*gnt_id_s +: 4] : 4'd0;
    assign mul_y         = mul_i_valid ? bus.req_y[4*gnt_id_s +: 4] : 4'd0;

    // The oldest tag lines up with the multiplier's output in the same cycle.
    assign tail_s   = tag_q[LAT-1];
    assign rsp_hs_s = rsp_valid_q & bus.rsp_ready;
    assign wb_s     = mul_o_valid & tail_s.v;

    // Next-state for pending flags, result buffers, pointer and error flag.
    always_comb begin
        pend_d      = (pend_q | grant_s) & ~rsp_hs_s;
        rsp_valid_d = rsp_valid_q & ~rsp_hs_s;
        rsp_data_d  = rsp_data_q;
        // A lane being written back has its pend set, so it cannot be in a
        // response handshake this cycle; the two updates never collide.
        if (wb_s) begin
            rsp_valid_d[tail_s.id]       = 1'b1;
            rsp_data_d[8*tail_s.id +: 8] = mul_cout;
        end else begin
        end
        if (mul_i_valid) begin
            ptr_d = gnt_id_s + IW'(1);
        end else begin
            ptr_d = ptr_q;
        end
        // Either a result with no owner or an owner with no result.
        err_d = err_q | (mul_o_valid ^ tail_s.v);
    end

    // Any valid tag still in the pipeline.
    always_comb begin
        tag_any_s = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            tag_any_s = tag_any_s | tag_q[k].v;
        end
    end

    assign busy          = tag_any_s | (|rsp_valid_q);
    assign err           = err_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    // State registers; reset discards in-flight tags and buffered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
            end
            pend_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            ptr_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            tag_q[0] <= '{v: mul_i_valid, id: gnt_id_s};
            for (int k = 1; k < LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            pend_q      <= pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
        end
    end
endmodule
